// File: rtl/cache_pkg.sv
// Shared constants, address layout, FSM states and block word select for the direct-mapped read cache.
package cache_pkg;

  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned TAG_W    = 3;
  localparam int unsigned INDEX_W  = 10;
  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BLOCK_W  = 128;
  localparam int unsigned LINES    = 1024;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_REQ = 2'd1,
    FILL    = 2'd2
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } addr_t;

  // Word k of a block sits at bits [32k+31:32k]; the bit position is offset*32.
  function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                  input logic [OFFSET_W-1:0] off);
    return blk[{off, 5'd0} +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_array.sv
// Line storage: resettable valid bits plus unreset tag/data arrays, combinational read and one sync write.
module cache_array
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  rd_index,
  output logic                rd_valid_c,
  output logic [TAG_W-1:0]    rd_tag_c,
  output logic [BLOCK_W-1:0]  rd_block_c,
  input  logic                we,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [BLOCK_W-1:0]  wr_block
);

  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tags  [LINES];
  logic [BLOCK_W-1:0] data  [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data contents survive reset; only the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_block;
    end
  end

  assign rd_valid_c = valid[rd_index];
  assign rd_tag_c   = tags[rd_index];
  assign rd_block_c = data[rd_index];

endmodule

// File: rtl/direct_mapped_cache.sv
// Read-only direct-mapped cache: 1-cycle hits, 3-cycle misses via a one-cycle block read to memory.
module direct_mapped_cache
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic [ADDR_W-1:0]   addr,
  output logic [WORD_W-1:0]   rdata,
  output logic                ready,
  output logic                busy,
  output logic                mem_read,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [BLOCK_W-1:0]  mem_rdata,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    access_count
);

  state_t             state, next_state;
  addr_t              req_a, lat_a;
  logic               accept_c, hit_c, fill_c;
  logic               rd_valid_c;
  logic [TAG_W-1:0]   rd_tag_c;
  logic [BLOCK_W-1:0] rd_block_c;

  assign req_a = addr;

  cache_array u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_index   (req_a.index),
    .rd_valid_c (rd_valid_c),
    .rd_tag_c   (rd_tag_c),
    .rd_block_c (rd_block_c),
    .we         (fill_c),
    .wr_index   (lat_a.index),
    .wr_tag     (lat_a.tag),
    .wr_block   (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state and per-cycle strobes; requests are only looked at in IDLE.
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    hit_c      = 1'b0;
    fill_c     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept_c = 1'b1;
          if (rd_valid_c && (rd_tag_c == req_a.tag)) hit_c = 1'b1;
          else                                       next_state = MEM_REQ;
        end
      end
      MEM_REQ: next_state = FILL;
      FILL: begin
        fill_c     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs, latched request and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_a        <= '0;
      rdata        <= '0;
      ready        <= 1'b0;
      busy         <= 1'b0;
      mem_read     <= 1'b0;
      mem_addr     <= '0;
      hit_count    <= '0;
      access_count <= '0;
    end else begin
      ready    <= hit_c | fill_c;
      busy     <= (next_state != IDLE);
      mem_read <= (next_state == MEM_REQ);
      if (accept_c) begin
        lat_a        <= req_a;
        access_count <= access_count + CNT_W'(1);
      end
      if (hit_c) begin
        rdata     <= word_sel(rd_block_c, req_a.offset);
        hit_count <= hit_count + CNT_W'(1);
      end
      if (accept_c && !hit_c) mem_addr <= {req_a.tag, req_a.index, OFFSET_W'(0)};
      if (fill_c) rdata <= word_sel(mem_rdata, lat_a.offset);
    end
  end

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Directed bench for direct_mapped_cache with a one-cycle registered block memory model.
module tb_direct_mapped_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic [14:0]  addr;
  logic [31:0]  rdata;
  logic         ready;
  logic         busy;
  logic         mem_read;
  logic [14:0]  mem_addr;
  logic [127:0] mem_rdata = '0;
  logic [15:0]  hit_count;
  logic [15:0]  access_count;

  int checks = 0;
  int errors = 0;

  direct_mapped_cache dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .addr         (addr),
    .rdata        (rdata),
    .ready        (ready),
    .busy         (busy),
    .mem_read     (mem_read),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .hit_count    (hit_count),
    .access_count (access_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [14:0] a);
    return 32'hC0DE_0000 ^ {17'd0, a};
  endfunction

  // Main memory: registers the requested block on the edge that ends the read cycle.
  always @(posedge clk) begin
    if (mem_read)
      mem_rdata <= {w(mem_addr + 15'd3), w(mem_addr + 15'd2), w(mem_addr + 15'd1), w(mem_addr)};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request; waits (bounded) for ready and checks latency, data and memory traffic.
  task automatic rd(input string tag, input logic [14:0] a, input int exp_lat);
    int lat;
    int mr;
    logic [14:0] ma;
    req  = 1'b1;
    addr = a;
    @(posedge clk); #1;
    req  = 1'b0;
    addr = 15'h7FFF;
    lat  = 1;
    mr   = 0;
    ma   = '0;
    while (!ready && lat < 10) begin
      if (mem_read) begin mr++; ma = mem_addr; end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":rdata"}, rdata, w(a));
    chk({tag, ":mem_reads"}, 32'(mr), (exp_lat == 3) ? 32'd1 : 32'd0);
    if (exp_lat == 3) chk({tag, ":mem_addr"}, 32'(ma), 32'(a & 15'h7FFC));
  endtask

  task automatic cnt(input string tag, input logic [15:0] exp_hit, input logic [15:0] exp_acc);
    chk({tag, ":hit_count"}, 32'(hit_count), 32'(exp_hit));
    chk({tag, ":access_count"}, 32'(access_count), 32'(exp_acc));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    req   = 1'b0;
    addr  = '0;
    #13;
    chk("rst:rdata", rdata, 32'd0);
    chk("rst:ready", 32'(ready), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:mem_read", 32'(mem_read), 32'd0);
    chk("rst:mem_addr", 32'(mem_addr), 32'd0);
    cnt("rst", 16'd0, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    rd("cold_miss", 15'h0405, 3);
    cnt("cold_miss", 16'd0, 16'd1);
    rd("hit", 15'h0406, 1);
    cnt("hit", 16'd1, 16'd2);
    rd("b2b_hit0", 15'h0404, 1);
    rd("b2b_hit1", 15'h0407, 1);
    cnt("b2b", 16'd3, 16'd4);

    // Evicting miss with a request pulsed during FILL that must be dropped.
    req = 1'b1; addr = 15'h1405;
    @(posedge clk); #1;
    req = 1'b0;
    chk("drop:busy_memreq", 32'(busy), 32'd1);
    chk("drop:mem_read", 32'(mem_read), 32'd1);
    chk("drop:mem_addr", 32'(mem_addr), 32'h1404);
    @(posedge clk); #1;
    chk("drop:busy_fill", 32'(busy), 32'd1);
    req = 1'b1; addr = 15'h0010;
    @(posedge clk); #1;
    req = 1'b0;
    chk("drop:ready", 32'(ready), 32'd1);
    chk("drop:rdata", rdata, w(15'h1405));
    cnt("drop", 16'd3, 16'd5);
    @(posedge clk); #1;
    chk("drop:idle_busy", 32'(busy), 32'd0);
    chk("drop:idle_mem_read", 32'(mem_read), 32'd0);
    rd("after_drop", 15'h0010, 3);
    rd("evicted", 15'h0405, 3);
    cnt("evicted", 16'd3, 16'd7);

    // Reset while in MEM_REQ aborts the fill.
    req = 1'b1; addr = 15'h0604;
    @(posedge clk); #1;
    req = 1'b0;
    chk("midrst:mem_read", 32'(mem_read), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst:busy", 32'(busy), 32'd0);
    chk("midrst:mem_read0", 32'(mem_read), 32'd0);
    chk("midrst:mem_addr", 32'(mem_addr), 32'd0);
    cnt("midrst", 16'd0, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst:no_ready", 32'(ready), 32'd0);
    rd("midrst_reread", 15'h0604, 3);
    cnt("midrst_reread", 16'd0, 16'd1);

    rd("conflict0", 15'h0404, 3);
    rd("conflict1", 15'h1404, 3);
    rd("conflict2", 15'h0404, 3);
    cnt("conflict", 16'd0, 16'd4);

    // Back-to-back hits every cycle up to hit_count = 0xFFFF.
    req = 1'b1; addr = 15'h0404; n = 0;
    while (hit_count !== 16'hFFFF && n < 70000) begin
      @(posedge clk); #1;
      n++;
    end
    req = 1'b0;
    chk("wrap:cycles", 32'(n), 32'd65535);
    cnt("wrap_pre", 16'hFFFF, 16'd3);
    rd("wrap_hit", 15'h0407, 1);
    cnt("wrap", 16'h0000, 16'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
